// File: rtl/imem_reader_pkg.sv
// Shared definitions for the instruction-memory readback block.
package imem_reader_pkg;

  // Readback FSM state encoding.
  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRd   = 3'd1,
    StCap  = 3'd2,
    StOut  = 3'd3,
    StFin  = 3'd4
  } imem_rd_state_e;

  // Cycles from the imem_reb=0 edge until imem_rdata is valid. The FSM moves
  // straight from the read cycle to the capture cycle, so it assumes this is 1.
  localparam int unsigned ReadLatency = 1;

endpackage

// File: rtl/imem_reader.sv
// Walks an inclusive, possibly wrapping address range of an external
// instruction memory. Each word is presented on a valid/ready handshake, and a
// running XOR checksum of the accepted words is kept.
module imem_reader
  import imem_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] first_addr,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  output logic [ADDR_WIDTH-1:0] imem_addr_output,
  output logic                  imem_reb,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum
);

  imem_rd_state_e        state;
  logic [ADDR_WIDTH-1:0] counter;
  logic [ADDR_WIDTH-1:0] end_addr;
  logic [ADDR_WIDTH-1:0] counter_next;

  // Address increment that wraps at RAM_DEPTH, even when the depth is not a
  // power of two.
  always_comb begin
    counter_next = counter + 1'b1;
    if (counter == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
      counter_next = '0;
    end
  end

  assign busy = (state != StIdle);

  // Readback FSM. All outputs are registered. The read strobe and address are
  // set on the edge that enters StRd, so they are valid for exactly that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= StIdle;
      counter          <= '0;
      end_addr         <= '0;
      imem_addr_output <= '0;
      imem_reb         <= 1'b1;
      out_data         <= '0;
      out_addr         <= '0;
      out_valid        <= 1'b0;
      done             <= 1'b0;
      checksum         <= '0;
    end else begin
      done     <= 1'b0;
      imem_reb <= 1'b1;
      unique case (state)
        StIdle: begin
          if (start) begin
            counter          <= first_addr;
            end_addr         <= last_addr;
            checksum         <= '0;
            imem_addr_output <= first_addr;
            imem_reb         <= 1'b0;
            state            <= StRd;
          end
        end
        StRd: begin
          state <= StCap;
        end
        StCap: begin
          out_data  <= imem_rdata;
          out_addr  <= counter;
          out_valid <= 1'b1;
          state     <= StOut;
        end
        StOut: begin
          if (out_ready) begin
            checksum  <= checksum ^ out_data;
            out_valid <= 1'b0;
            if (counter == end_addr) begin
              done  <= 1'b1;
              state <= StFin;
            end else begin
              counter          <= counter_next;
              imem_addr_output <= counter_next;
              imem_reb         <= 1'b0;
              state            <= StRd;
            end
          end
        end
        StFin: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_reader.sv
// Directed bench for imem_reader: table of readback runs plus hand-written
// reset and abort sequences.
module tb_imem_reader;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned Depth = 32;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] first_addr;
  logic [AW-1:0] last_addr;
  logic [AW-1:0] imem_addr_output;
  logic          imem_reb;
  logic [DW-1:0] imem_rdata;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic [DW-1:0] checksum;

  logic [DW-1:0] mem [Depth];

  int tests;
  int fails;

  imem_reader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .RAM_DEPTH (Depth)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .first_addr      (first_addr),
    .last_addr       (last_addr),
    .imem_addr_output(imem_addr_output),
    .imem_reb        (imem_reb),
    .imem_rdata      (imem_rdata),
    .out_data        (out_data),
    .out_addr        (out_addr),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .busy            (busy),
    .done            (done),
    .checksum        (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory model: data appears one cycle after the strobe.
  always @(posedge clk) begin
    if (!imem_reb) imem_rdata <= mem[imem_addr_output];
  end

  typedef struct {
    string        name;
    logic [AW-1:0] first;
    logic [AW-1:0] last;
    int           n_words;
    int           stall_idx;
    int           stall_cycles;
    bit           busy_start;
    bit           chk_ck1;
    logic [DW-1:0] ck1;
    logic [DW-1:0] ck;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input vec_t v);
    int n;
    int rd;
    int dones;
    int cyc;
    int stall_left;
    int first_valid;
    bit pend_ck1;
    logic [AW-1:0] ea;
    n = 0; rd = 0; dones = 0; cyc = 1; first_valid = 0; pend_ck1 = 0;
    stall_left = v.stall_cycles;
    first_addr = v.first;
    last_addr  = v.last;
    start      = 1'b1;
    tick();
    start = 1'b0;
    check({v.name, " busy_after_start"}, 32'(busy), 32'd1);
    while (cyc < 400 && dones == 0) begin
      start = 1'b0;
      out_ready = 1'b1;
      if (pend_ck1) begin
        check({v.name, " checksum_word1"}, checksum, v.ck1);
        pend_ck1 = 0;
      end
      if (!imem_reb) rd++;
      if (out_valid) begin
        if (first_valid == 0) first_valid = cyc;
        ea = AW'((int'(v.first) + n) % Depth);
        check({v.name, " out_addr"}, 32'(out_addr), 32'(ea));
        check({v.name, " out_data"}, out_data, mem[ea]);
        if (n == v.stall_idx && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          if (n == 1 && v.chk_ck1) pend_ck1 = 1;
          n++;
        end
      end
      if (done) dones++;
      if (v.busy_start && (cyc == 4 || done)) begin
        start      = 1'b1;
        first_addr = 5'd9;
        last_addr  = 5'd12;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    check({v.name, " done_count"}, 32'(dones), 32'd1);
    check({v.name, " first_valid_cycle"}, 32'(first_valid), 32'd3);
    check({v.name, " words"}, 32'(n), 32'(v.n_words));
    check({v.name, " reads"}, 32'(rd), 32'(v.n_words));
    check({v.name, " checksum"}, checksum, v.ck);
    check({v.name, " done_pulse_width"}, 32'(done), 32'd0);
    check({v.name, " idle_after"}, 32'(busy), 32'd0);
    tick();
    check({v.name, " stays_idle"}, 32'(busy), 32'd0);
    check({v.name, " checksum_hold"}, checksum, v.ck);
  endtask

  initial begin
    int k;
    bit saw_done;
    tests = 0;
    fails = 0;
    mem[0] = 32'h00500113;
    mem[1] = 32'h00C00193;
    mem[2] = 32'hFF718393;
    for (int i = 3; i < int'(Depth); i++) mem[i] = 32'h1000_0000 + 32'(i);

    vecs[0] = '{"basic", 5'd0, 5'd2, 3, -1, 0, 1'b0, 1'b1, 32'h00900080, 32'hFFE18313};
    vecs[1] = '{"stall", 5'd0, 5'd2, 3, 1, 5, 1'b0, 1'b1, 32'h00900080, 32'hFFE18313};
    vecs[2] = '{"wrap", 5'd30, 5'd1, 4, -1, 0, 1'b0, 1'b0, 32'h0, 32'h00900081};
    vecs[3] = '{"single", 5'd6, 5'd6, 1, -1, 0, 1'b0, 1'b0, 32'h0, 32'h10000006};
    vecs[4] = '{"busy_start", 5'd0, 5'd2, 3, -1, 0, 1'b1, 1'b1, 32'h00900080, 32'hFFE18313};
    vecs[5] = '{"full_depth", 5'd3, 5'd2, 32, -1, 0, 1'b0, 1'b0, 32'h0, 32'hEFE18310};

    // Reset with start held high: reset must win.
    reset = 1'b1; start = 1'b1; first_addr = 5'd4; last_addr = 5'd5; out_ready = 1'b0;
    tick();
    tick();
    check("rst busy", 32'(busy), 32'd0);
    check("rst imem_reb", 32'(imem_reb), 32'd1);
    check("rst imem_addr", 32'(imem_addr_output), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst out_data", out_data, 32'd0);
    check("rst out_addr", 32'(out_addr), 32'd0);
    check("rst checksum", checksum, 32'd0);
    reset = 1'b0; start = 1'b0;
    tick();

    // Abort during OUT of the second word.
    first_addr = 5'd0; last_addr = 5'd2; start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (k < 20 && !(out_valid && out_addr == 5'd1)) begin
      tick();
      k++;
    end
    check("abort reached_word1", 32'(out_valid && out_addr == 5'd1), 32'd1);
    out_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort checksum", checksum, 32'd0);
    check("abort imem_reb", 32'(imem_reb), 32'd1);
    saw_done = done;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    check("abort no_done", 32'(saw_done), 32'd0);
    check("abort still_idle", 32'(busy), 32'd0);

    for (int i = 0; i < 6; i++) run(vecs[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
